// File: rtl/serial_parity_checker_if.sv
// Serial parity checker bus: serial receive inputs plus frame result and error status.
interface serial_parity_checker_if #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 bit_in;
    logic                 bit_valid;
    logic                 frame_start;
    logic                 clr_err;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_abort;
    logic                 busy;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 err_sticky;

    modport master (
        output bit_in, bit_valid, frame_start, clr_err,
        input  data_out, data_valid, parity_err, frame_abort, busy, err_count, err_sticky
    );

    modport slave (
        input  bit_in, bit_valid, frame_start, clr_err,
        output data_out, data_valid, parity_err, frame_abort, busy, err_count, err_sticky
    );
endinterface

// File: rtl/serial_parity_checker.sv
// Serial parity checker: reassembles LSB-first frames, checks the trailing parity bit,
// and keeps a saturating error count plus a sticky error flag.
module serial_parity_checker #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned ODD_PARITY = 0,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input logic                    clk,
    input logic                    reset,
    serial_parity_checker_if.slave bus
);
    localparam int unsigned CNT_W   = $clog2(DATA_BITS + 1);
    localparam logic        ODD_BIT = 1'(ODD_PARITY);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 dv_q, dv_d;
    logic                 perr_q, perr_d;
    logic                 abort_q, abort_d;
    logic                 busy_q;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 sticky_q, sticky_d;

    // Next-state, datapath and status update; only valid bits advance the frame.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        perr_d    = 1'b0;
        abort_d   = 1'b0;
        err_cnt_d = err_cnt_q;
        sticky_d  = sticky_q;

        if (bus.bit_valid) begin
            if (bus.frame_start) begin
                // A start bit always opens a fresh frame, dropping any partial one.
                abort_d = (state_q != IDLE);
                shift_d = DATA_BITS'(bus.bit_in);
                par_d   = bus.bit_in;
                cnt_d   = CNT_W'(1);
                state_d = DATA;
            end else begin
                case (state_q)
                    DATA: begin
                        shift_d = shift_q | (DATA_BITS'(bus.bit_in) << cnt_q);
                        par_d   = par_q ^ bus.bit_in;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                            state_d = PARITY;
                        end
                    end
                    PARITY: begin
                        data_d  = shift_q;
                        dv_d    = 1'b1;
                        perr_d  = par_q ^ bus.bit_in ^ ODD_BIT;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                    default: ;
                endcase
            end
        end

        // A new error outranks a simultaneous clear.
        if (perr_d) begin
            sticky_d = 1'b1;
            if (bus.clr_err) begin
                err_cnt_d = ERR_CNT_W'(1);
            end else if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end else if (bus.clr_err) begin
            err_cnt_d = '0;
            sticky_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= '0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            abort_q   <= abort_d;
            busy_q    <= (state_d != IDLE);
            err_cnt_q <= err_cnt_d;
            sticky_q  <= sticky_d;
        end
    end

    assign bus.data_out    = data_q;
    assign bus.data_valid  = dv_q;
    assign bus.parity_err  = perr_q;
    assign bus.frame_abort = abort_q;
    assign bus.busy        = busy_q;
    assign bus.err_count   = err_cnt_q;
    assign bus.err_sticky  = sticky_q;
endmodule
